// File: rtl/wb_sel_ctrl.sv
// wb_sel_ctrl: writeback-select control for a 4-stage tail (ID -> EX -> MEM -> WB).
// Decodes the writeback source, destination and write enable in ID, and carries
// them down the EX/MEM/WB stage registers. It also raises a load-use stall when
// the instruction in ID needs the result of a load that is still in EX.
module wb_sel_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       stall_in,
    input  logic       flush,
    output logic       hazard_stall,
    output logic [1:0] wb_sel,
    output logic [4:0] wb_rd,
    output logic       wb_reg_write
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    // Writeback mux select encodings
    localparam logic [1:0] SEL_DATA  = 2'b00;
    localparam logic [1:0] SEL_AUIPC = 2'b01;
    localparam logic [1:0] SEL_LINK  = 2'b10;
    localparam logic [1:0] SEL_LUI   = 2'b11;

    // Stage indices into the pipeline register array
    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    typedef struct packed {
        logic       vld;
        logic [1:0] sel;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } stage_t;

    // An all-zero entry is a bubble: invalid, no write, data select, not a load.
    localparam stage_t BUBBLE = '0;

    stage_t     pipe_q [3];
    stage_t     ex_next;
    logic [1:0] dec_sel;
    logic       dec_rw;
    logic       dec_ld;
    logic       no_rs_read;

    // Decode the ID instruction into writeback select, write enable and load flag.
    always_comb begin
        dec_sel = SEL_DATA;
        dec_rw  = 1'b0;
        dec_ld  = 1'b0;
        case (id_opcode)
            OP_LUI:   begin dec_sel = SEL_LUI;   dec_rw = 1'b1; end
            OP_AUIPC: begin dec_sel = SEL_AUIPC; dec_rw = 1'b1; end
            OP_JAL:   begin dec_sel = SEL_LINK;  dec_rw = 1'b1; end
            OP_JALR:  begin dec_sel = SEL_LINK;  dec_rw = 1'b1; end
            OP_REG:   dec_rw = 1'b1;
            OP_IMM:   dec_rw = 1'b1;
            OP_LOAD:  begin dec_rw = 1'b1; dec_ld = 1'b1; end
            default:  ;
        endcase
        // x0 is hardwired; never request a write to it
        if (id_rd == 5'd0) begin
            dec_rw = 1'b0;
        end
    end

    // LUI/AUIPC/JAL read no source registers, so their rs fields are don't-care.
    assign no_rs_read = (id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) || (id_opcode == OP_JAL);

    // Load-use detection against the load currently in EX; freeze and flush win.
    always_comb begin
        hazard_stall = id_valid && pipe_q[EX].vld && pipe_q[EX].ld &&
                       (pipe_q[EX].rd != 5'd0) &&
                       ((pipe_q[EX].rd == id_rs1) || (pipe_q[EX].rd == id_rs2)) &&
                       !no_rs_read && !stall_in && !flush;
    end

    // Select what EX captures: the decoded ID fields, or a bubble on flush/load-use.
    always_comb begin
        ex_next = '{vld: id_valid, sel: dec_sel, rd: id_rd, rw: dec_rw, ld: dec_ld};
        if (flush || hazard_stall) begin
            ex_next = BUBBLE;
        end
    end

    // Stage registers: cleared on reset, frozen under stall_in, otherwise shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pipe_q[i] <= BUBBLE;
            end
        end else if (!stall_in) begin
            pipe_q[EX]  <= ex_next;
            pipe_q[MEM] <= pipe_q[EX];
            pipe_q[WB]  <= pipe_q[MEM];
        end
    end

    // Writeback outputs; an invalid WB entry never writes and selects data.
    assign wb_rd        = pipe_q[WB].rd;
    assign wb_reg_write = pipe_q[WB].vld & pipe_q[WB].rw;
    assign wb_sel       = pipe_q[WB].vld ? pipe_q[WB].sel : SEL_DATA;

endmodule
